// File: rtl/execute_stage_inner_pkg.sv
// execute_stage_inner_pkg: pipeline status, opcode and instruction types shared by the execute stage
package execute_stage_inner_pkg;
    localparam logic [31:0] INSTR_SIZE = 32'd4;
    typedef enum logic [3:0] {
        ST_VALID, ST_BUBBLE, ST_FETCH_MISALIGNED, ST_FETCH_FAULT, ST_ILLEGAL_INSTRUCTION
    } forwards_t;
    typedef enum logic [1:0] {BW_READY, BW_STALL, BW_JUMP} backwards_t;
    typedef enum logic [5:0] {
        OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_SLTU,
        OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLLI, OP_SRLI, OP_SRAI, OP_SLTI, OP_SLTIU,
        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW,
        OP_CSRRW, OP_CSRRS, OP_CSRRC, OP_CSRRWI, OP_CSRRSI, OP_CSRRCI,
        OP_ECALL, OP_EBREAK, OP_MRET, OP_FENCE
    } op_t;
    typedef struct packed {
        op_t         op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [11:0] csr;
        logic [31:0] imm;
    } instruction_t;
    typedef struct packed {
        logic        data_valid;
        logic [4:0]  rd_address;
        logic [31:0] data;
    } forwarding_t;
    // Branches, memory, CSR and system ops never produce a forwardable result here
    function automatic logic forwardable(op_t op);
        return !(op inside {[OP_BEQ:OP_FENCE]});
    endfunction
endpackage

// File: rtl/execute_stage_inner_if.sv
// execute_stage_inner_if: decode/memory-facing signal bundle of the execute stage
interface execute_stage_inner_if;
    import execute_stage_inner_pkg::*;
    forwards_t    status_forwards_in;
    forwards_t    status_forwards_out;
    backwards_t   status_backwards_in;
    backwards_t   status_backwards_out;
    logic [31:0]  rs1_data_in;
    logic [31:0]  rs2_data_in;
    instruction_t instruction_in;
    logic [31:0]  program_counter_in;
    logic [31:0]  source_data_reg_out;
    logic [31:0]  rd_data_reg_out;
    instruction_t instruction_reg_out;
    logic [31:0]  program_counter_reg_out;
    logic [31:0]  next_program_counter_reg_out;
    logic [31:0]  jump_address_backwards_in;
    logic [31:0]  jump_address_backwards_out;
    forwarding_t  forwarding_out;
    modport master (
        output status_forwards_in, status_backwards_in, rs1_data_in, rs2_data_in,
               instruction_in, program_counter_in, jump_address_backwards_in,
        input  status_forwards_out, status_backwards_out, source_data_reg_out, rd_data_reg_out,
               instruction_reg_out, program_counter_reg_out, next_program_counter_reg_out,
               jump_address_backwards_out, forwarding_out
    );
    modport slave (
        input  status_forwards_in, status_backwards_in, rs1_data_in, rs2_data_in,
               instruction_in, program_counter_in, jump_address_backwards_in,
        output status_forwards_out, status_backwards_out, source_data_reg_out, rd_data_reg_out,
               instruction_reg_out, program_counter_reg_out, next_program_counter_reg_out,
               jump_address_backwards_out, forwarding_out
    );
endinterface

// File: rtl/execute_stage_inner_alu.sv
// execute_stage_inner_alu: RV32I register/immediate arithmetic, logic, shift and compare
module execute_stage_inner_alu
    import execute_stage_inner_pkg::*;
(
    input  op_t         op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] result_o
);
    always_comb begin
        case (op_i)
            OP_ADD, OP_ADDI:   result_o = a_i + b_i;
            OP_SUB:            result_o = a_i - b_i;
            OP_AND, OP_ANDI:   result_o = a_i & b_i;
            OP_OR, OP_ORI:     result_o = a_i | b_i;
            OP_XOR, OP_XORI:   result_o = a_i ^ b_i;
            OP_SLL, OP_SLLI:   result_o = a_i << b_i[4:0];
            OP_SRL, OP_SRLI:   result_o = a_i >> b_i[4:0];
            OP_SRA, OP_SRAI:   result_o = $unsigned($signed(a_i) >>> b_i[4:0]);
            OP_SLT, OP_SLTI:   result_o = {31'd0, $signed(a_i) < $signed(b_i)};
            OP_SLTU, OP_SLTIU: result_o = {31'd0, a_i < b_i};
            default:           result_o = '0;
        endcase
    end
endmodule

// File: rtl/execute_stage_inner.sv
// execute_stage_inner: RV32I execute stage computing results/targets and holding the EX/MEM register
module execute_stage_inner
    import execute_stage_inner_pkg::*;
(
    input logic clk,
    input logic rst,
    execute_stage_inner_if.slave bus
);
    instruction_t ins, instr_q;
    logic [31:0] rs1, rs2, pc, imm, alu_b, alu_res, target, jump_out;
    logic [31:0] rd_data_d, rd_data_q, src_q, pc_q, next_pc_d, next_pc_q;
    logic taken, stall;
    forwards_t status_d, status_q;
    backwards_t bw_out;
    assign ins = bus.instruction_in;
    assign rs1 = bus.rs1_data_in;
    assign rs2 = bus.rs2_data_in;
    assign pc = bus.program_counter_in;
    assign imm = ins.imm;
    assign alu_b = ins.op inside {[OP_ADD:OP_SLTU]} ? rs2 : imm;
    execute_stage_inner_alu u_alu (.op_i(ins.op), .a_i(rs1), .b_i(alu_b), .result_o(alu_res));
    always_comb begin
        rd_data_d = alu_res;
        case (ins.op)
            OP_LUI:                                   rd_data_d = imm;
            OP_AUIPC:                                 rd_data_d = pc + imm;
            OP_JAL, OP_JALR:                          rd_data_d = pc + INSTR_SIZE;
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
            OP_SB, OP_SH, OP_SW:                      rd_data_d = rs1 + imm;
            OP_CSRRW, OP_CSRRS, OP_CSRRC:             rd_data_d = rs1;
            OP_CSRRWI, OP_CSRRSI, OP_CSRRCI:          rd_data_d = {27'd0, ins.rs1};
            default: ;
        endcase
    end
    always_comb begin
        case (ins.op)
            OP_JAL, OP_JALR: taken = 1'b1;
            OP_BEQ:          taken = rs1 == rs2;
            OP_BNE:          taken = rs1 != rs2;
            OP_BLT:          taken = $signed(rs1) < $signed(rs2);
            OP_BGE:          taken = $signed(rs1) >= $signed(rs2);
            OP_BLTU:         taken = rs1 < rs2;
            OP_BGEU:         taken = rs1 >= rs2;
            default:         taken = 1'b0;
        endcase
    end
    assign target = ins.op == OP_JALR ? (rs1 + imm) & ~32'd1 : pc + imm;
    assign next_pc_d = taken ? target : pc + INSTR_SIZE;
    assign stall = bus.status_backwards_in == BW_STALL;
    // A downstream redirect outranks everything; our own redirect needs a VALID, aligned target
    always_comb begin
        status_d = bus.status_forwards_in;
        bw_out = BW_READY;
        jump_out = '0;
        if (bus.status_backwards_in == BW_JUMP) begin
            bw_out = BW_JUMP;
            jump_out = bus.jump_address_backwards_in;
            status_d = ST_BUBBLE;
        end else if (stall) begin
            bw_out = BW_STALL;
        end else if (bus.status_forwards_in == ST_VALID && taken) begin
            if (target[1]) begin
                status_d = ST_FETCH_MISALIGNED;
            end else begin
                bw_out = BW_JUMP;
                jump_out = target;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            status_q <= ST_BUBBLE;
            rd_data_q <= '0;
            src_q <= '0;
            instr_q <= '0;
            pc_q <= '0;
            next_pc_q <= '0;
        end else if (!stall) begin
            status_q <= status_d;
            rd_data_q <= rd_data_d;
            src_q <= rs2;
            instr_q <= ins;
            pc_q <= pc;
            next_pc_q <= next_pc_d;
        end
    end
    assign bus.status_forwards_out = status_q;
    assign bus.status_backwards_out = bw_out;
    assign bus.jump_address_backwards_out = jump_out;
    assign bus.source_data_reg_out = src_q;
    assign bus.rd_data_reg_out = rd_data_q;
    assign bus.instruction_reg_out = instr_q;
    assign bus.program_counter_reg_out = pc_q;
    assign bus.next_program_counter_reg_out = next_pc_q;
    assign bus.forwarding_out = {status_q == ST_VALID && instr_q.rd != 5'd0 && forwardable(instr_q.op),
                                 instr_q.rd, rd_data_q};
endmodule

// File: tb/tb_execute_stage_inner.sv
// tb_execute_stage_inner: randomized and directed checks of the execute stage against a reference model
module tb_execute_stage_inner;
    import execute_stage_inner_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    execute_stage_inner_if bus();
    execute_stage_inner dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    logic [3:0] fwd;
    logic [1:0] bw;
    logic [31:0] rs1, rs2, pc, jin;
    logic [64:0] ins;
    logic [3:0] m_st;
    logic [31:0] m_rd, m_src, m_pc, m_npc;
    logic [64:0] m_ins;

    task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] arith(input int k, input logic [31:0] a, input logic [31:0] b);
        int sh = int'(b[4:0]);
        case (k)
            1: return a + b;
            2: return a - b;
            3: return a & b;
            4: return a | b;
            5: return a ^ b;
            6: return a << sh;
            7: return a >> sh;
            8: return a[31] ? ~((~a) >> sh) : a >> sh;
            9: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            10: return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [64:0] mk(input int op, input int r1, input int r2, input int rd, input logic [31:0] imm);
        logic [5:0] o = op[5:0];
        logic [4:0] a = r1[4:0];
        logic [4:0] b = r2[4:0];
        logic [4:0] d = rd[4:0];
        return {o, a, b, d, 12'h000, imm};
    endfunction

    task automatic model(output logic [31:0] rd, output logic [31:0] tgt, output logic [31:0] npc, output bit tk);
        int op = int'(ins[64:59]);
        logic [31:0] imm = ins[31:0];
        int imap[9] = '{1, 3, 4, 5, 6, 7, 8, 9, 10};
        rd = 32'd0;
        tk = 1'b0;
        tgt = pc + imm;
        if (op >= 1 && op <= 10) rd = arith(op, rs1, rs2);
        else if (op >= 11 && op <= 19) rd = arith(imap[op - 11], rs1, imm);
        else if (op == 20) rd = imm;
        else if (op == 21) rd = pc + imm;
        else if (op == 22 || op == 23) begin
            rd = pc + 32'd4;
            tk = 1'b1;
            if (op == 23) tgt = (rs1 + imm) & 32'hFFFF_FFFE;
        end
        else if (op == 24) tk = rs1 == rs2;
        else if (op == 25) tk = rs1 != rs2;
        else if (op == 26) tk = $signed(rs1) < $signed(rs2);
        else if (op == 27) tk = !($signed(rs1) < $signed(rs2));
        else if (op == 28) tk = rs1 < rs2;
        else if (op == 29) tk = !(rs1 < rs2);
        else if (op >= 30 && op <= 37) rd = rs1 + imm;
        else if (op >= 38 && op <= 40) rd = rs1;
        else if (op >= 41 && op <= 43) rd = {27'd0, ins[58:54]};
        npc = tk ? tgt : pc + 32'd4;
    endtask

    task automatic cycle();
        logic [31:0] rd, tgt, npc, eja;
        logic [1:0] ebw;
        logic [3:0] est;
        logic [37:0] efw;
        bit tk;
        bus.status_forwards_in = forwards_t'(fwd);
        bus.status_backwards_in = backwards_t'(bw);
        bus.rs1_data_in = rs1;
        bus.rs2_data_in = rs2;
        bus.instruction_in = ins;
        bus.program_counter_in = pc;
        bus.jump_address_backwards_in = jin;
        model(rd, tgt, npc, tk);
        est = fwd;
        ebw = 2'd0;
        eja = 32'd0;
        if (bw == 2'd2) begin
            ebw = 2'd2;
            eja = jin;
            est = 4'd1;
        end else if (bw == 2'd1) begin
            ebw = 2'd1;
        end else if (fwd == 4'd0 && tk) begin
            if (tgt[1]) est = 4'd2;
            else begin
                ebw = 2'd2;
                eja = tgt;
            end
        end
        #1;
        if (!rst) begin
            check("status_backwards_out", 65'(bus.status_backwards_out), 65'(ebw));
            check("jump_address_backwards_out", 65'(bus.jump_address_backwards_out), 65'(eja));
        end
        @(posedge clk);
        if (rst) begin
            m_st = 4'd1;
            m_rd = '0;
            m_src = '0;
            m_ins = '0;
            m_pc = '0;
            m_npc = '0;
        end else if (bw != 2'd1) begin
            m_st = est;
            m_rd = rd;
            m_src = rs2;
            m_ins = ins;
            m_pc = pc;
            m_npc = npc;
        end
        #1;
        efw = {m_st == 4'd0 && m_ins[48:44] != 5'd0 && !(int'(m_ins[64:59]) inside {[24:47]}), m_ins[48:44], m_rd};
        check("status_forwards_out", 65'(bus.status_forwards_out), 65'(m_st));
        check("rd_data_reg_out", 65'(bus.rd_data_reg_out), 65'(m_rd));
        check("source_data_reg_out", 65'(bus.source_data_reg_out), 65'(m_src));
        check("instruction_reg_out", 65'(bus.instruction_reg_out), m_ins);
        check("program_counter_reg_out", 65'(bus.program_counter_reg_out), 65'(m_pc));
        check("next_program_counter_reg_out", 65'(bus.next_program_counter_reg_out), 65'(m_npc));
        check("forwarding_out", 65'(bus.forwarding_out), 65'(efw));
    endtask

    task automatic randomize_inputs();
        logic [31:0] imm = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 63)) - 32'd32;
        ins = mk(int'($urandom_range(0, 47)), int'($urandom), int'($urandom),
                 $urandom_range(0, 3) == 0 ? 0 : int'($urandom), imm);
        rs1 = $urandom;
        rs2 = $urandom_range(0, 3) == 0 ? rs1 : $urandom;
        pc = $urandom & 32'hFFFF_FFFC;
        jin = $urandom;
        fwd = $urandom_range(0, 3) == 0 ? 4'($urandom_range(0, 15)) : 4'd0;
        bw = $urandom_range(0, 5) == 0 ? 2'd1 : ($urandom_range(0, 7) == 0 ? 2'd2 : 2'd0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) begin
            randomize_inputs();
            cycle();
        end
        check("reset status", 65'(bus.status_forwards_out), 65'(ST_BUBBLE));
        check("reset forwarding", 65'(bus.forwarding_out), 65'd0);
        check("reset rd_data", 65'(bus.rd_data_reg_out), 65'd0);
        rst = 1'b0;
        fwd = 4'd0; bw = 2'd0; jin = 32'd0;
        ins = mk(1, 0, 0, 3, 32'd0); rs1 = 32'd5; rs2 = 32'd7; pc = 32'h40;
        cycle();
        check("add rd_data", 65'(bus.rd_data_reg_out), 65'd12);
        check("add next_pc", 65'(bus.next_program_counter_reg_out), 65'h44);
        check("add forwarding", 65'(bus.forwarding_out), 65'({1'b1, 5'd3, 32'd12}));
        check("add bw_out", 65'(bus.status_backwards_out), 65'(BW_READY));
        ins = mk(24, 0, 0, 0, 32'd8); rs1 = 32'd9; rs2 = 32'd9; pc = 32'h100;
        cycle();
        check("beq taken bw_out", 65'(bus.status_backwards_out), 65'(BW_JUMP));
        check("beq taken jump", 65'(bus.jump_address_backwards_out), 65'h108);
        check("beq taken next_pc", 65'(bus.next_program_counter_reg_out), 65'h108);
        rs2 = 32'd1;
        cycle();
        check("beq not taken bw_out", 65'(bus.status_backwards_out), 65'(BW_READY));
        check("beq not taken next_pc", 65'(bus.next_program_counter_reg_out), 65'h104);
        ins = mk(23, 0, 0, 1, 32'd4); rs1 = 32'h203; pc = 32'h80;
        cycle();
        check("jalr misaligned status", 65'(bus.status_forwards_out), 65'(ST_FETCH_MISALIGNED));
        check("jalr misaligned bw_out", 65'(bus.status_backwards_out), 65'(BW_READY));
        rs1 = 32'h201;
        cycle();
        check("jalr bw_out", 65'(bus.status_backwards_out), 65'(BW_JUMP));
        check("jalr jump", 65'(bus.jump_address_backwards_out), 65'h204);
        check("jalr link", 65'(bus.rd_data_reg_out), 65'h84);
        ins = mk(1, 0, 0, 4, 32'd0); rs1 = 32'd1; rs2 = 32'd2; pc = 32'h10;
        cycle();
        repeat (3) begin
            randomize_inputs();
            bw = 2'd1;
            cycle();
            check("stall rd_data held", 65'(bus.rd_data_reg_out), 65'd3);
            check("stall bw_out", 65'(bus.status_backwards_out), 65'(BW_STALL));
        end
        ins = mk(1, 0, 0, 4, 32'd0); rs1 = 32'd10; rs2 = 32'd20; pc = 32'h20; fwd = 4'd0; bw = 2'd0;
        cycle();
        check("after stall rd_data", 65'(bus.rd_data_reg_out), 65'd30);
        ins = mk(25, 0, 0, 0, 32'h10); rs1 = 32'd1; rs2 = 32'd2; pc = 32'h200; bw = 2'd2; jin = 32'h500;
        cycle();
        check("downstream jump address", 65'(bus.jump_address_backwards_out), 65'h500);
        check("downstream jump bubble", 65'(bus.status_forwards_out), 65'(ST_BUBBLE));
        for (int i = 0; i < 600; i++) begin
            randomize_inputs();
            rst = $urandom_range(0, 63) == 0;
            cycle();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
